// File: rtl/approx_add_pkg.sv
// Shared defaults, slot-state type and helper functions for the
// approximate-adder scheduler.
package approx_add_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_BITS = 7;
    localparam int DEF_NREQ        = 4;
    localparam int DEF_ERR_W       = 24;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Adds two values and clamps the result at the all-ones value of a w-bit field.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [64:0] s;
        logic [63:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/approx_rc_adder.sv
// Ripple-carry adder whose low APPROX_BITS cells are OR/AND approximations
// and whose upper cells are exact full adders.
module approx_rc_adder #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0]           s;
    logic [WIDTH:APPROX_BITS]   c;

    // Approximate cells ignore their carry-in, so only the last one feeds the exact chain.
    generate
        if (APPROX_BITS > 0) begin : g_approx
            assign s[APPROX_BITS-1:0] = a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0];
            assign c[APPROX_BITS]     = a[APPROX_BITS-1] & b[APPROX_BITS-1];
        end else begin : g_noapprox
            assign c[APPROX_BITS] = 1'b0;
        end

        for (genvar k = APPROX_BITS; k < WIDTH; k++) begin : g_exact
            assign s[k]   = a[k] ^ b[k] ^ c[k];
            assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
        end
    endgenerate

    assign sum = {c[WIDTH], s};

endmodule

// File: rtl/approx_add_sched.sv
// Round-robin scheduler sharing one approximate adder among NREQ requesters,
// with a one-entry result slot and saturating error statistics.
module approx_add_sched
    import approx_add_pkg::*;
#(
    parameter  int WIDTH       = DEF_WIDTH,
    parameter  int APPROX_BITS = DEF_APPROX_BITS,
    parameter  int NREQ        = DEF_NREQ,
    parameter  int ERR_W       = DEF_ERR_W,
    localparam int ID_W        = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic [WIDTH:0]        rsp_err,
    input  logic                  stats_clr,
    output logic [ERR_W-1:0]      op_count,
    output logic [ERR_W-1:0]      err_acc,
    output logic [WIDTH:0]        err_max
);

    slot_state_t      state, state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  cand;
    logic             has_win;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic [WIDTH:0]   approx_sum, exact_sum, err;
    logic [ERR_W-1:0] op_count_nxt, err_acc_nxt;
    logic [WIDTH:0]   err_max_nxt;
    int               idx;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        has_win = 1'b0;
        winner  = '0;
        cand    = '0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = ID_W'(idx);
            if (!has_win && req_valid[cand]) begin
                has_win = 1'b1;
                winner  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)                          state_nxt = FULL;
        else if (state == FULL && rsp_ready) state_nxt = EMPTY;
    end

    always_comb begin
        rsp_valid = (state == FULL);
        slot_free = (state == EMPTY) || rsp_ready;
        req_ready = '0;
        if (has_win && slot_free) req_ready[winner] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);
    assign a_sel  = req_a[winner*WIDTH +: WIDTH];
    assign b_sel  = req_b[winner*WIDTH +: WIDTH];

    approx_rc_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_adder (
        .a   (a_sel),
        .b   (b_sel),
        .sum (approx_sum)
    );

    assign exact_sum = {1'b0, a_sel} + {1'b0, b_sel};
    assign err       = (approx_sum > exact_sum) ? (approx_sum - exact_sum)
                                                : (exact_sum - approx_sum);

    // A clear coinciding with an accept restarts the statistics from that operation.
    always_comb begin
        op_count_nxt = op_count;
        err_acc_nxt  = err_acc;
        err_max_nxt  = err_max;
        if (stats_clr) begin
            op_count_nxt = accept ? ERR_W'(1) : '0;
            err_acc_nxt  = accept ? ERR_W'(err) : '0;
            err_max_nxt  = accept ? err : '0;
        end else if (accept) begin
            op_count_nxt = ERR_W'(sat_add(64'(op_count), 64'd1, ERR_W));
            err_acc_nxt  = ERR_W'(sat_add(64'(err_acc), 64'(err), ERR_W));
            if (err > err_max) err_max_nxt = err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_err  <= '0;
            op_count <= '0;
            err_acc  <= '0;
            err_max  <= '0;
        end else begin
            op_count <= op_count_nxt;
            err_acc  <= err_acc_nxt;
            err_max  <= err_max_nxt;
            if (accept) begin
                rsp_id  <= winner;
                rsp_sum <= approx_sum;
                rsp_err <= err;
                if (int'(winner) == NREQ - 1) ptr <= '0;
                else                          ptr <= winner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_sched.sv
// Directed self-checking bench for approx_add_sched; a second instance with
// an 8-bit statistics width shares the stimulus to exercise saturation.
module tb_approx_add_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic        rsp_ready;
    logic        stats_clr;

    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [8:0]  rsp_sum, rsp_err, err_max;
    logic [23:0] op_count, err_acc;

    logic [3:0]  s_req_ready;
    logic        s_rsp_valid;
    logic [1:0]  s_rsp_id;
    logic [8:0]  s_rsp_sum, s_rsp_err, s_err_max;
    logic [7:0]  s_op_count, s_err_acc;

    int total = 0;
    int fails = 0;

    approx_add_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .stats_clr (stats_clr),
        .op_count  (op_count),
        .err_acc   (err_acc),
        .err_max   (err_max)
    );

    approx_add_sched #(.ERR_W(8)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (s_req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (s_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (s_rsp_id),
        .rsp_sum   (s_rsp_sum),
        .rsp_err   (s_rsp_err),
        .stats_clr (stats_clr),
        .op_count  (s_op_count),
        .err_acc   (s_err_acc),
        .err_max   (s_err_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst_v, input logic [3:0] valid,
                                 input logic rdy, input logic clr);
        @(negedge clk);
        rst_n     = rst_v;
        req_valid = valid;
        rsp_ready = rdy;
        stats_clr = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkRsp(input string tag, input logic [1:0] id,
                            input logic [8:0] sum, input logic [8:0] err);
        checkOutput({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        checkOutput({tag, ".id"},    64'(rsp_id),    64'(id));
        checkOutput({tag, ".sum"},   64'(rsp_sum),   64'(sum));
        checkOutput({tag, ".err"},   64'(rsp_err),   64'(err));
    endtask

    // Requester i operands: 0:0F+01, 1:FF+01, 2:80+80, 3:40+40.
    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        stats_clr = 1'b0;
        req_a     = {8'h40, 8'h80, 8'hFF, 8'h0F};
        req_b     = {8'h40, 8'h80, 8'h01, 8'h01};
        $display("[TB] start");

        tick();
        tick();
        checkOutput("reset.valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset.sum",   64'(rsp_sum),   64'd0);
        checkOutput("reset.count", 64'(op_count),  64'd0);

        // Requester 0 only, one vector at a time
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        req_a[7:0] = 8'h0F; req_b[7:0] = 8'h01; #1;
        checkOutput("r0.v1.ready", 64'(req_ready), 64'b0001);
        tick();
        checkRsp("r0.v1", 2'd0, 9'h00F, 9'd1);
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        req_a[7:0] = 8'hFF; req_b[7:0] = 8'h01; #1;
        checkOutput("r0.v2.ready", 64'(req_ready), 64'b0001);
        tick();
        checkRsp("r0.v2", 2'd0, 9'h0FF, 9'd1);
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        req_a[7:0] = 8'h80; req_b[7:0] = 8'h80;
        tick();
        checkRsp("r0.v3", 2'd0, 9'h100, 9'd0);
        applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
        req_a[7:0] = 8'h40; req_b[7:0] = 8'h40;
        tick();
        checkRsp("r0.v4", 2'd0, 9'h0C0, 9'd64);
        checkOutput("r0.count", 64'(op_count), 64'd4);
        checkOutput("r0.acc",   64'(err_acc),  64'd66);
        checkOutput("r0.max",   64'(err_max),  64'd64);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        req_a[7:0] = 8'h0F; req_b[7:0] = 8'h01;
        tick();
        checkOutput("drain.valid", 64'(rsp_valid), 64'd0);

        // Reset, then all requesters valid continuously
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("rr0.ready", 64'(req_ready), 64'b0001);
        tick();
        checkRsp("rr0", 2'd0, 9'h00F, 9'd1);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("rr1.ready", 64'(req_ready), 64'b0010);
        tick();
        checkRsp("rr1", 2'd1, 9'h0FF, 9'd1);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("rr2.ready", 64'(req_ready), 64'b0100);
        tick();
        checkRsp("rr2", 2'd2, 9'h100, 9'd0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("rr3.ready", 64'(req_ready), 64'b1000);
        tick();
        checkRsp("rr3", 2'd3, 9'h0C0, 9'd64);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("rr4.ready", 64'(req_ready), 64'b0001);
        tick();
        checkRsp("rr4", 2'd0, 9'h00F, 9'd1);

        // Backpressure for five cycles while holding a result
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.ready", 64'(req_ready), 64'd0);
            tick();
            checkRsp("bp.hold", 2'd0, 9'h00F, 9'd1);
        end
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        checkOutput("bp.release.ready", 64'(req_ready), 64'b0010);
        tick();
        checkRsp("bp.release", 2'd1, 9'h0FF, 9'd1);

        // Clear coinciding with an accept of 0x40+0x40
        applyStimulus(1'b1, 4'b1000, 1'b1, 1'b1);
        checkOutput("clr.ready", 64'(req_ready), 64'b1000);
        tick();
        checkOutput("clr.count", 64'(op_count), 64'd1);
        checkOutput("clr.acc",   64'(err_acc),  64'd64);
        checkOutput("clr.max",   64'(err_max),  64'd64);
        checkOutput("clr.sat.acc", 64'(s_err_acc), 64'd64);

        // Four more accepts of error 64: narrow accumulator saturates at 255
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0);
            tick();
            checkOutput("sat.acc", 64'(s_err_acc), (k * 64 > 255) ? 64'd255 : 64'(k * 64));
            checkOutput("wide.acc", 64'(err_acc), 64'(k * 64));
        end
        checkOutput("sat.count", 64'(s_op_count), 64'd5);
        checkOutput("wide.count", 64'(op_count), 64'd5);

        // Move the pointer off zero, then reset while stalled
        applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0);
        checkOutput("pre.ready", 64'(req_ready), 64'b0010);
        tick();
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0);
        tick();
        checkOutput("rst.valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst.id",    64'(rsp_id),    64'd0);
        checkOutput("rst.count", 64'(op_count),  64'd0);
        checkOutput("rst.acc",   64'(err_acc),   64'd0);
        checkOutput("rst.max",   64'(err_max),   64'd0);
        applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
        checkOutput("post.ready", 64'(req_ready), 64'b0010);
        tick();
        checkRsp("post", 2'd1, 9'h0FF, 9'd1);
        checkOutput("post.count", 64'(op_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule

// File: doc/approx_add_sched.md
# approx_add_sched

Round-robin scheduler that shares one approximate ripple-carry adder (low `APPROX_BITS` cells approximate, upper cells exact) among `NREQ` requesters over valid/ready handshakes. It registers each result together with the requester ID. It also computes the exact sum in parallel and keeps saturating error statistics (operation count, accumulated absolute error, maximum error) for on-line MAE monitoring. It sits between operand producers and downstream consumers in the approximate-arithmetic evaluation datapath.

## Interface
- `WIDTH`, 8, operand width; sum is `WIDTH+1` bits
- `APPROX_BITS`, 7, number of LSB cells using the approximate cell; legal range 0..`WIDTH-1`
- `NREQ`, 4, number of requesters, ≥2
- `ERR_W`, 24, width of the error accumulator and of the op counter

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset; synchronous, active-low
- `req_valid` in `NREQ`: per-requester operand valid
- `req_ready` out `NREQ`: per-requester accept; one-hot or zero
- `req_a`, `req_b` in `NREQ*WIDTH`: packed operands; requester i occupies `[i*WIDTH +: WIDTH]`
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accept
- `rsp_id` out `$clog2(NREQ)`: index of the requester that issued the result
- `rsp_sum` out `WIDTH+1`: approximate sum
- `rsp_err` out `WIDTH+1`: |exact − approximate|
- `stats_clr` in 1: synchronous clear of the statistics
- `op_count` out `ERR_W`: accepted operations, saturating
- `err_acc` out `ERR_W`: sum of `rsp_err` over accepted operations, saturating
- `err_max` out `WIDTH+1`: maximum `rsp_err` since the last clear

## Operation
- Approximate cell at bit k < `APPROX_BITS`:
  - s = a|b, cout = a&b.
  - Carry-in is ignored; bit 0 has carry-in 0.
- Exact cells at bits ≥ `APPROX_BITS` are standard full adders.
  - The carry into bit `APPROX_BITS` is the cout of the last approximate cell.
  - The cout of bit `WIDTH-1` is `rsp_sum[WIDTH]`.
- Exact sum is `a+b`, zero-extended to `WIDTH+1`. `rsp_err` is the absolute difference; the approximate sum may be above or below the exact sum.
- Output slot states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- Slot free this cycle = EMPTY, or FULL with `rsp_ready`=1.
- Arbitration:
  - Round-robin pointer `ptr`.
  - Winner = first i with `req_valid[i]`, searching from `ptr` upward modulo `NREQ`.
  - `req_ready[winner]`=1 only when the slot is free. `req_ready` is combinational from `req_valid`, `rsp_valid` and `rsp_ready`.
- Accept (`req_valid[i]&req_ready[i]`):
  - Next edge loads `rsp_sum`, `rsp_err`, `rsp_id`=i and sets FULL.
  - `ptr` ← i+1 mod `NREQ`.
- Drain without accept (FULL, `rsp_ready`=1, no winner): next state is EMPTY.
- While FULL and `rsp_ready`=0: all response outputs hold stable and all `req_ready` are 0.
- Statistics update on accept only:
  - `op_count`+1 and `err_acc`+`rsp_err`, each saturating at all-ones.
  - `err_max` ← max(`err_max`, err).
- `stats_clr` zeroes all three statistics. `stats_clr` together with an accept loads that operation's values (count=1, acc=err, max=err).
- Reset (any cycle, including mid-transaction) values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_err`=0.
  - `ptr`=0.
  - All statistics 0.
  - An in-flight result is discarded.

## Timing
- Latency: operand accept edge to `rsp_valid` = 1 cycle.
- Throughput: 1 operation/cycle with `rsp_ready` held high.
- The adder path is combinational from the muxed operands to the output register. There is no internal pipelining.
- Statistics become visible on the same edge that loads the response.
- `rst_n` is sampled on the clock edge. All outputs show reset values on the first edge with `rst_n`=0, and the block accepts on the first cycle after `rst_n`=1.

## Structure
- Package `approx_add_pkg`:
  - Defaults for `WIDTH`, `APPROX_BITS`, `NREQ`, `ERR_W`.
  - Function for `$clog2(NREQ)` ID width.
  - Saturating-add function.
  - Slot state enum {EMPTY, FULL}.
- Sub-module `approx_rc_adder` (params `WIDTH`, `APPROX_BITS`): purely combinational, returns the `WIDTH+1` approximate sum. The scheduler instantiates it once and computes the exact sum and absolute difference itself.

## Test plan
- Defaults; requester 0 only:
  - 0x0F+0x01 → `rsp_sum`=0x00F, `rsp_err`=1.
  - 0xFF+0x01 → 0x0FF, err 1.
  - 0x80+0x80 → 0x100, err 0.
  - 0x40+0x40 → 0x0C0, err 64.
  - Then `op_count`=4, `err_acc`=66, `err_max`=64.
- All four requesters valid continuously after reset, `rsp_ready`=1 → grants 0,1,2,3,0 on consecutive cycles; `rsp_id` follows one cycle later.
- Backpressure: `rsp_ready`=0 for 5 cycles while FULL → all `req_ready`=0 and `rsp_*` stable; on release, the next winner is accepted in the same cycle.
- `stats_clr` in the same cycle as an accept of 0x40+0x40 → `op_count`=1, `err_acc`=64, `err_max`=64.
- Saturation (`ERR_W`=8): accept 0x40+0x40 five times → `err_acc`=255 and holds.
- `rst_n` low for one cycle while FULL with `rsp_ready`=0 → `rsp_valid`=0, stats 0, `ptr`=0; next grant goes to the lowest valid index.
